mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port main memory.
- Port 0 serves the instruction-side cache refill path; port 1 serves the data-side cache refill/write-back path.
- Accepts one word access per grant, drives the memory's read/write strobes for exactly one cycle and waits for its registered ready.
- Returns a one-cycle ack, with read data for reads, to the winning port. Simultaneous requests are resolved round-robin.

Parameters:
- ADDR_W, 32, address width passed through to memory.
- DATA_W, 32, data word width.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_we  in  1  port 0 write enable (1=write, 0=read).
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_W  port 0 read data, valid when p0_ack=1 for a read.
- p0_err  out  1  timeout flag, valid with p0_ack.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_err: same as port 0, for port 1.
- mem_address  out  ADDR_W  to memory.
- mem_read  out  1  to memory.
- mem_write  out  1  to memory.
- mem_wdata  out  DATA_W  to memory.
- mem_data_out  in  DATA_W  from memory.
- mem_ready  in  1  from memory ready, registered one cycle after a strobe.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - All acks, errs, mem_read and mem_write = 0.
  - mem_address, mem_wdata, p0_rdata, p1_rdata = 0.
  - last_grant=1, so port 0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Samples p0_req and p1_req.
  - Only one high: that port is granted.
  - Both high: the port != last_grant is granted.
  - On grant: latch addr, we and wdata into mem_address, mem_wdata and an internal we; update last_grant; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_read=~we or mem_write=we; never both.
  - Go to WAIT.
- WAIT:
  - mem_read=mem_write=0; mem_address and mem_wdata stay stable.
  - mem_ready=1: for a read, capture mem_data_out into the granted port's rdata register; go to ACK.
  - mem_ready=0: stay in WAIT.
- ACK (exactly 1 cycle):
  - Granted port's ack=1; other port's ack=0.
  - Go to IDLE; requests are not sampled in ACK.
- Writes leave the rdata registers unchanged.
- Minimum latency: req high in cycle 0 gives ack in cycle 3. Peak throughput is one access per 4 cycles.
- A requester that keeps req high in the cycle after its ack is treated as issuing a new request.
- req deasserted before ack: undefined usage. The arbiter completes the latched transaction regardless; the bench never relies on it.
- The non-granted port's req is ignored until the next IDLE. It then wins, since last_grant points to the other port (no starvation).
- Addresses pass through unmodified; no alignment checking (memory uses bits 13:2).
- mem_ready=1 observed in IDLE, ISSUE or ACK is ignored.
- rst_n asserted mid-transaction: the transaction is abandoned with no ack, and all registers return to reset values immediately.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering WAIT and increments each WAIT cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES: go to ACK with the granted port's err=1 and rdata=0 for reads.
  - err is cleared with ack.
  - mem_ready arriving in the same cycle as the limit wins: normal completion, err=0.
- Not defined:
  - WAIT holds indefinitely until mem_ready.
  - p0_err and p1_err are tied 0; no counter is instantiated.

Test Plan:
- Reset then p0 read of addr 0x0000_0010 (memory word 4 = 0x1234_5678): mem_read high exactly one cycle in cycle 1 with mem_address=0x10; p0_ack in cycle 3 with p0_rdata=0x1234_5678; p1_ack stays 0.
- p1 write addr 0x0000_0020, wdata 0xCAFE_F00D, then p1 read of the same address: mem_write pulses once, p1_ack after 3 cycles; the read returns 0xCAFE_F00D; p1_rdata is unchanged by the write.
- p0_req and p1_req both raised in the same cycle after reset, both held: order is p0, p1, p0, p1 over four transactions; acks spaced every 4 cycles.
- p1 requesting continuously while p0 raises req mid-p1 transaction: p0 is served next, before p1's following request.
- Reset pulsed low during WAIT: all outputs 0 immediately; no ack afterwards; the next p0 read completes normally.
- MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, memory model holding mem_ready=0: p0_ack with p0_err=1 and p0_rdata=0 after 8 WAIT cycles. With the macro undefined, no ack occurs within 100 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin arbiter and access sequencer in
// front of the single-port main memory. Port 0 is the instruction refill path
// and port 1 is the data refill/write-back path.
//
// Each grant performs one word access. The FSM runs IDLE -> ISSUE -> WAIT ->
// ACK. The read or write strobe is high for exactly the ISSUE cycle. The FSM
// then waits for the memory's registered ready, and the granted port gets a
// one-cycle ack, with read data for reads. All outputs are registered.
//
// Handshake: a port raises req with we/addr/wdata stable and holds them until
// its ack. The ack is a single-cycle pulse. A req still high in the cycle
// after the ack is taken as a new request.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles. An expired wait completes with err=1 and rdata=0.
// When the macro is undefined, p0_err and p1_err are tied low and no counter
// is built.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    // TIMEOUT_CYCLES must be at least 1; this empty block marks a bad setting
    // in the elaborated hierarchy.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_invalid
    end

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;   // port served most recently
    logic              gnt_q, gnt_d;                 // port owning the current access
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              sel_p1;
    logic              sel_we;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             p0_err_q, p0_err_d;
    logic             p1_err_q, p1_err_d;
`endif

    // Next-state and output-register logic for the access sequencer
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        gnt_d         = gnt_q;
        we_d          = we_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        p0_ack_d      = 1'b0;
        p1_ack_d      = 1'b0;
        p0_rdata_d    = p0_rdata_q;
        p1_rdata_d    = p1_rdata_q;
        sel_p1        = 1'b0;
        sel_we        = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        p0_err_d      = 1'b0;
        p1_err_d      = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    // On a tie the port that did not win last time is chosen.
                    if (p0_req && p1_req) begin
                        sel_p1 = ~last_grant_q;
                    end else begin
                        sel_p1 = p1_req;
                    end
                    sel_we        = sel_p1 ? p1_we : p0_we;
                    gnt_d         = sel_p1;
                    last_grant_d  = sel_p1;
                    we_d          = sel_we;
                    mem_address_d = sel_p1 ? p1_addr : p0_addr;
                    mem_wdata_d   = sel_p1 ? p1_wdata : p0_wdata;
                    mem_read_d    = ~sel_we;
                    mem_write_d   = sel_we;
                    state_d       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // The strobe was high for this cycle only.
                state_d = S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end

            S_WAIT: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        if (gnt_q) begin
                            p1_rdata_d = mem_data_out;
                        end else begin
                            p0_rdata_d = mem_data_out;
                        end
                    end
                    if (gnt_q) begin
                        p1_ack_d = 1'b1;
                    end else begin
                        p0_ack_d = 1'b1;
                    end
                    state_d = S_ACK;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    // A ready arriving in this same cycle takes the branch above.
                    if (gnt_q) begin
                        p1_ack_d = 1'b1;
                        p1_err_d = 1'b1;
                        if (!we_q) begin
                            p1_rdata_d = '0;
                        end
                    end else begin
                        p0_ack_d = 1'b1;
                        p0_err_d = 1'b1;
                        if (!we_q) begin
                            p0_rdata_d = '0;
                        end
                    end
                    state_d = S_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            S_ACK: begin
                // Requests are not sampled here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            gnt_q         <= 1'b0;
            we_q          <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            p0_ack_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
            p0_rdata_q    <= '0;
            p1_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            gnt_q         <= gnt_d;
            we_q          <= we_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            p0_ack_q      <= p0_ack_d;
            p1_ack_q      <= p1_ack_d;
            p0_rdata_q    <= p0_rdata_d;
            p1_rdata_q    <= p1_rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // WAIT-cycle counter and timeout error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            p0_err_q   <= p0_err_d;
            p1_err_q   <= p1_err_d;
        end
    end

    assign p0_err = p0_err_q;
    assign p1_err = p1_err_q;
`else
    assign p0_err = 1'b0;
    assign p1_err = 1'b0;
`endif

    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign p0_ack      = p0_ack_q;
    assign p1_ack      = p1_ack_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. It contains a behavioural memory
// with registered ready that can be stalled through mem_stall. Inputs are
// driven and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack, p0_err, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_wdata, mem_data_out;
  logic          mem_ready;

  logic          mem_stall;
  logic [DW-1:0] mem_arr [0:4095];

  int            n_checks;
  int            n_errors;
  int            n;
  int            acks;
  int            last_n;
  logic          seen;
  logic [0:0]    exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .p0_req(p0_req),
    .p0_we(p0_we),
    .p0_addr(p0_addr),
    .p0_wdata(p0_wdata),
    .p0_ack(p0_ack),
    .p0_rdata(p0_rdata),
    .p0_err(p0_err),
    .p1_req(p1_req),
    .p1_we(p1_we),
    .p1_addr(p1_addr),
    .p1_wdata(p1_wdata),
    .p1_ack(p1_ack),
    .p1_rdata(p1_rdata),
    .p1_err(p1_err),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_wdata(mem_wdata),
    .mem_data_out(mem_data_out),
    .mem_ready(mem_ready)
  );

  // Memory model: word-indexed by bits 13:2, ready registered one cycle after a strobe
  always @(posedge clk) begin
    mem_ready <= (mem_read | mem_write) & ~mem_stall;
    if (mem_read) mem_data_out <= mem_arr[mem_address[13:2]];
    if (mem_write) mem_arr[mem_address[13:2]] <= mem_wdata;
    if (!rst_n) mem_arr[4] <= 32'h1234_5678;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One access on one port, checking latency, strobe, address/data and response
  task automatic run_txn(input bit port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
    int          cnt;
    int          rd_cnt;
    int          wr_cnt;
    int          strobe_n;
    logic [31:0] strobe_addr;
    logic [31:0] strobe_wdata;
    logic        got;
    logic        other_ack;
    cnt = 0; rd_cnt = 0; wr_cnt = 0; strobe_n = 0;
    strobe_addr = '0; strobe_wdata = '0; got = 1'b0; other_ack = 1'b0;
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
    while (!got && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_read | mem_write) begin
        strobe_n = cnt;
        strobe_addr = mem_address;
        strobe_wdata = mem_wdata;
      end
      if (port ? p0_ack : p1_ack) other_ack = 1'b1;
      if (port ? p1_ack : p0_ack) got = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cnt), 32'd3);
    check({tag, "_rd_strobes"}, 32'(rd_cnt), we ? 32'd0 : 32'd1);
    check({tag, "_wr_strobes"}, 32'(wr_cnt), we ? 32'd1 : 32'd0);
    check({tag, "_strobe_cycle"}, 32'(strobe_n), 32'd1);
    check({tag, "_addr"}, strobe_addr, addr);
    if (we) check({tag, "_wdata"}, strobe_wdata, wdata);
    check({tag, "_other_ack"}, 32'(other_ack), 32'd0);
    check({tag, "_err"}, 32'(port ? p1_err : p0_err), 32'd0);
    if (!we) check({tag, "_rdata"}, port ? p1_rdata : p0_rdata, exp_rd);
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mem_stall = 1'b0;
    rst_n = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

    // Reset state
    do_reset();
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_p0_ack", 32'(p0_ack), 32'd0);
    check("rst_p1_ack", 32'(p1_ack), 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_p1_rdata", p1_rdata, 32'd0);
    check("rst_p0_err", 32'(p0_err), 32'd0);
    check("rst_p1_err", 32'(p1_err), 32'd0);

    // Basic read on port 0, then port 1 read / write / read-back
    run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, "p0_rd");
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, "p1_rd");
    check("p0_rdata_kept", p0_rdata, 32'h1234_5678);
    run_txn(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, "p1_wr");
    check("p1_rdata_after_wr", p1_rdata, 32'h1234_5678);
    run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, "p1_rdback");

    // Reset pulsed while the access is parked in WAIT
    mem_stall = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0020;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_read", 32'(mem_read), 32'd0);
    check("mid_rst_mem_address", mem_address, 32'd0);
    check("mid_rst_p0_rdata", p0_rdata, 32'd0);
    check("mid_rst_p1_rdata", p1_rdata, 32'd0);
    check("mid_rst_p0_ack", 32'(p0_ack), 32'd0);
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_stall = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (p0_ack | p1_ack | mem_read | mem_write) seen = 1'b1;
    end
    check("post_rst_no_activity", 32'(seen), 32'd0);
    run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, "post_rst_rd");

    // Both ports request together after reset, both held: p0, p1, p0, p1
    do_reset();
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h0000_0020;
    n = 0; acks = 0; last_n = 0;
    while (acks < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (p0_ack | p1_ack) begin
        check("rr_single_ack", 32'(p0_ack & p1_ack), 32'd0);
        check("rr_order", 32'(p1_ack), 32'(exp_q.pop_front()));
        if (p1_ack) check("rr_p1_rdata", p1_rdata, 32'hCAFE_F00D);
        else check("rr_p0_rdata", p0_rdata, 32'h1234_5678);
        if (acks == 0) check("rr_first_latency", 32'(n), 32'd3);
        else check("rr_spacing", 32'(n - last_n), 32'd4);
        last_n = n;
        acks++;
        if (acks == 4) begin
          p0_req = 1'b0;
          p1_req = 1'b0;
        end
      end
    end
    check("rr_ack_count", 32'(acks), 32'd4);
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);

    // p1 streaming, p0 joins mid-transaction and must be served next
    exp_q = {1'b1, 1'b0, 1'b1};
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h0000_0020;
    p0_we = 1'b0; p0_addr = 32'h0000_0010;
    n = 0; acks = 0;
    while (acks < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 2) p0_req = 1'b1;
      if (p0_ack | p1_ack) begin
        check("pre_order", 32'(p1_ack), 32'(exp_q.pop_front()));
        if (p0_ack) p0_req = 1'b0;
        acks++;
        if (acks == 3) p1_req = 1'b0;
      end
    end
    check("pre_ack_count", 32'(acks), 32'd3);
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);

    // Memory never answers
    do_reset();
    run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, "to_prime_rd");
    mem_stall = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0010;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (p0_ack) seen = 1'b1;
    end
`ifdef MEM_ARB_TIMEOUT_EN
    check("to_ack_seen", 32'(seen), 32'd1);
    check("to_latency", 32'(n), 32'd10);
    check("to_err", 32'(p0_err), 32'd1);
    check("to_rdata_zero", p0_rdata, 32'd0);
    p0_req = 1'b0;
    @(negedge clk);
    check("to_err_cleared", 32'(p0_err), 32'd0);
`else
    check("stall_no_ack", 32'(seen), 32'd0);
    check("stall_no_err", 32'(p0_err), 32'd0);
    p0_req = 1'b0;
`endif
    mem_stall = 1'b0;
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
